// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin arbiter with registered one-hot grant and binary mux select; ARB_HOLD_EN adds burst-hold locking via req_last.
module mux_select_arbiter #(
    parameter int NUM_PORTS_WIDTH = 2,
    localparam int NUM_PORTS = 2 ** NUM_PORTS_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req,
`ifdef ARB_HOLD_EN
    input  logic [NUM_PORTS-1:0]       req_last,
`endif
    input  logic                       out_ready,
    output logic [NUM_PORTS-1:0]       grant,
    output logic [NUM_PORTS_WIDTH-1:0] select,
    output logic                       sel_valid,
    output logic                       data_valid
);
    localparam logic [NUM_PORTS_WIDTH-1:0] ONE = 1;
    logic [NUM_PORTS-1:0]       grant_q, grant_d;
    logic [NUM_PORTS_WIDTH-1:0] select_q, select_d;
    logic [NUM_PORTS_WIDTH-1:0] ptr_q, ptr_d;
    logic                       sel_valid_q, sel_valid_d;
    logic                       data_valid_q, data_valid_d;
    logic [NUM_PORTS_WIDTH-1:0] idx, win;
    logic                       found;
`ifdef ARB_HOLD_EN
    logic                       lock_q, lock_d;
`endif
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = ptr_q + NUM_PORTS_WIDTH'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    always_comb begin
        grant_d      = '0;
        select_d     = select_q;
        sel_valid_d  = 1'b0;
        ptr_d        = ptr_q;
        data_valid_d = sel_valid_q;
`ifdef ARB_HOLD_EN
        lock_d = lock_q;
        // While locked, select_q still names the owning port because it only changes on a grant.
        if (lock_q) begin
            if (out_ready && req[select_q]) begin
                grant_d[select_q] = 1'b1;
                sel_valid_d       = 1'b1;
                if (req_last[select_q]) begin
                    lock_d = 1'b0;
                    ptr_d  = select_q + ONE;
                end
            end
        end else if (out_ready && found) begin
            grant_d[win] = 1'b1;
            select_d     = win;
            sel_valid_d  = 1'b1;
            ptr_d        = win + ONE;
            lock_d       = !req_last[win];
        end
`else
        if (out_ready && found) begin
            grant_d[win] = 1'b1;
            select_d     = win;
            sel_valid_d  = 1'b1;
            ptr_d        = win + ONE;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= '0;
            select_q     <= '0;
            ptr_q        <= '0;
            sel_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
`ifdef ARB_HOLD_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            grant_q      <= grant_d;
            select_q     <= select_d;
            ptr_q        <= ptr_d;
            sel_valid_q  <= sel_valid_d;
            data_valid_q <= data_valid_d;
`ifdef ARB_HOLD_EN
            lock_q       <= lock_d;
`endif
        end
    end
    assign grant      = grant_q;
    assign select     = select_q;
    assign sel_valid  = sel_valid_q;
    assign data_valid = data_valid_q;
endmodule
